// File: rtl/mem_lock_pkg.sv
// Shared definitions for the two-core memory lock arbiter.
//   state_t           : arbiter FSM states (IDLE, OWN0, OWN1)
//   MAX_HOLD_DEFAULT  : default cap on consecutive cycles one core may hold the lock
//   HOLD_CNT_W        : width of the hold counter (covers MAX_HOLD up to 255)
package mem_lock_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam int unsigned MAX_HOLD_DEFAULT = 64;
    localparam int unsigned HOLD_CNT_W       = 8;

endpackage

// File: rtl/lock_hold_timer.sv
// Hold timer for the memory lock arbiter.
// Counts cycles of continuous ownership.
// It saturates at MAX_HOLD-1 instead of wrapping.
//   clk     : clock
//   rst     : synchronous active-low reset
//   clear   : force the count to 0 (grant entry, handoff or idle)
//   enable  : count this cycle (a core owns the lock)
//   expired : count has reached MAX_HOLD-1
//   cnt     : current hold count
module lock_hold_timer
    import mem_lock_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  enable,
    output logic                  expired,
    output logic [HOLD_CNT_W-1:0] cnt
);

    localparam logic [HOLD_CNT_W-1:0] LAST = HOLD_CNT_W'(MAX_HOLD - 1);

    assign expired = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_lock_arbiter.sv
// Two-core memory lock arbiter.
// Round-robin on simultaneous requests.
// Ownership is capped at MAX_HOLD cycles.
//   clk          : clock
//   rst          : synchronous active-low reset
//   need_lock    : per-core request level, held for the whole critical section
//   rel          : per-core one-cycle pulse ending the owner's critical section
//                  ("release" is a reserved word in SystemVerilog)
//   grant        : registered one-hot/zero ownership
//   lock         : registered stall, requesting but not granted
//   whose_turn   : registered, winner of the next simultaneous request
//   timeout_flag : registered sticky, grant revoked by hold expiry
//   busy         : registered, any grant active
module mem_lock_arbiter
    import mem_lock_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] need_lock,
    input  logic [1:0] rel,
    output logic [1:0] grant,
    output logic [1:0] lock,
    output logic       whose_turn,
    output logic [1:0] timeout_flag,
    output logic       busy
);

    state_t                  state, next_state;
    logic                    wt_next;
    logic [1:0]              tf_next;
    logic [1:0]              grant_next;
    logic                    timer_clear;
    logic                    timer_en;
    logic                    expired;
    logic [HOLD_CNT_W-1:0]   hold_cnt;

    lock_hold_timer #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (expired),
        .cnt     (hold_cnt)
    );

    always_comb begin
        next_state = state;
        wt_next    = whose_turn;
        tf_next    = timeout_flag;

        unique case (state)
            IDLE: begin
                if (need_lock == 2'b11) begin
                    next_state = whose_turn ? OWN1 : OWN0;
                    wt_next    = ~whose_turn;
                end else if (need_lock[0]) begin
                    next_state = OWN0;
                    wt_next    = 1'b1;
                end else if (need_lock[1]) begin
                    next_state = OWN1;
                    wt_next    = 1'b0;
                end
            end
            OWN0: begin
                if (rel[0] || !need_lock[0] || expired) begin
                    // Expiry only counts as a timeout when nothing else ended ownership.
                    if (!rel[0] && need_lock[0]) begin
                        tf_next[0] = 1'b1;
                    end
                    if (need_lock[1]) begin
                        next_state = OWN1;
                        wt_next    = 1'b0;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            OWN1: begin
                if (rel[1] || !need_lock[1] || expired) begin
                    if (!rel[1] && need_lock[1]) begin
                        tf_next[1] = 1'b1;
                    end
                    if (need_lock[0]) begin
                        next_state = OWN0;
                        wt_next    = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase

        unique case (next_state)
            OWN0:    grant_next = 2'b01;
            OWN1:    grant_next = 2'b10;
            default: grant_next = 2'b00;
        endcase

        // Restart the count on any change of owner, and hold it at 0 while idle.
        timer_clear = (next_state != state) || (next_state == IDLE);
        timer_en    = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            grant        <= '0;
            lock         <= '0;
            whose_turn   <= 1'b0;
            timeout_flag <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= next_state;
            grant        <= grant_next;
            lock         <= need_lock & ~grant_next;
            whose_turn   <= wt_next;
            timeout_flag <= tf_next;
            busy         <= |grant_next;
        end
    end

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Self-checking bench for mem_lock_arbiter.
// It runs with MAX_HOLD = 8.
module tb_mem_lock_arbiter;

    localparam int unsigned MH = 8;

    logic       clk;
    logic       rst;
    logic [1:0] need_lock;
    logic [1:0] rel;
    logic [1:0] grant;
    logic [1:0] lock;
    logic       whose_turn;
    logic [1:0] timeout_flag;
    logic       busy;

    int checks = 0;
    int errors = 0;

    mem_lock_arbiter #(
        .MAX_HOLD (MH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .need_lock    (need_lock),
        .rel          (rel),
        .grant        (grant),
        .lock         (lock),
        .whose_turn   (whose_turn),
        .timeout_flag (timeout_flag),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] need;
        logic [1:0] rel;
        logic [1:0] grant;
        logic [1:0] lock;
        logic       wt;
        logic [1:0] tf;
        logic       busy;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic [1:0] n, input logic [1:0] l);
        rst       = r;
        need_lock = n;
        rel       = l;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] g, input logic [1:0] lk,
                             input logic wt, input logic [1:0] tf, input logic b);
        check({tag, " grant"}, 8'(grant), 8'(g));
        check({tag, " lock"}, 8'(lock), 8'(lk));
        check({tag, " whose_turn"}, 8'(whose_turn), 8'(wt));
        check({tag, " timeout_flag"}, 8'(timeout_flag), 8'(tf));
        check({tag, " busy"}, 8'(busy), 8'(b));
    endtask

    initial begin
        rst = 1'b0; need_lock = 2'b00; rel = 2'b00;

        //            rst   need   rel    grant  lock   wt    tf     busy
        vecs[0]  = '{1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0}; // reset dominates
        vecs[1]  = '{1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 1'b1, 2'b00, 1'b1}; // single request core 0
        vecs[2]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0}; // drop -> idle
        vecs[3]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0}; // reset
        vecs[4]  = '{1'b1, 2'b11, 2'b00, 2'b01, 2'b10, 1'b1, 2'b00, 1'b1}; // simultaneous
        vecs[5]  = '{1'b1, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1}; // release 0 -> handoff
        vecs[6]  = '{1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0}; // release 1 -> idle
        vecs[7]  = '{1'b1, 2'b11, 2'b00, 2'b01, 2'b10, 1'b1, 2'b00, 1'b1}; // fairness round 2
        vecs[8]  = '{1'b1, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1};
        vecs[9]  = '{1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0};
        vecs[10] = '{1'b1, 2'b11, 2'b00, 2'b01, 2'b10, 1'b1, 2'b00, 1'b1};
        vecs[11] = '{1'b1, 2'b11, 2'b01, 2'b10, 2'b01, 1'b0, 2'b00, 1'b1}; // release, core 0 still needs
        vecs[12] = '{1'b1, 2'b01, 2'b10, 2'b01, 2'b00, 1'b1, 2'b00, 1'b1}; // handoff back to 0
        vecs[13] = '{1'b1, 2'b01, 2'b10, 2'b01, 2'b00, 1'b1, 2'b00, 1'b1}; // non-owner release ignored
        vecs[14] = '{1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 1'b1, 2'b00, 1'b1};
        vecs[15] = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0}; // reset mid-OWN0
        vecs[16] = '{1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0}; // release in idle ignored
        vecs[17] = '{1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1}; // single request core 1
        vecs[18] = '{1'b1, 2'b11, 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, 1'b1}; // owner keeps lock
        vecs[19] = '{1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 1'b1, 2'b00, 1'b1}; // need drop -> handoff
        vecs[20] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0};
        vecs[21] = '{1'b1, 2'b11, 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, 1'b1}; // turn favours core 1
        vecs[22] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0};

        for (int i = 0; i < NV; i++) begin
            cycle(vecs[i].rst, vecs[i].need, vecs[i].rel);
            check_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].lock,
                      vecs[i].wt, vecs[i].tf, vecs[i].busy);
        end

        // Timeout: core 1 holds with no release.
        cycle(1'b0, 2'b00, 2'b00);
        for (int c = 1; c <= int'(MH); c++) begin
            cycle(1'b1, 2'b10, 2'b00);
            check($sformatf("to_hold%0d grant", c), 8'(grant), 8'h2);
            check($sformatf("to_hold%0d tf", c), 8'(timeout_flag), 8'h0);
        end
        cycle(1'b1, 2'b10, 2'b00);
        check_all("to_expire", 2'b00, 2'b10, 1'b0, 2'b10, 1'b0);
        check("to_expire hold_cnt", 8'(dut.hold_cnt), 8'h0);
        cycle(1'b1, 2'b00, 2'b00);
        check_all("to_sticky_idle", 2'b00, 2'b00, 1'b0, 2'b10, 1'b0);
        cycle(1'b1, 2'b01, 2'b00);
        check_all("to_sticky_grant", 2'b01, 2'b00, 1'b1, 2'b10, 1'b1);

        // Timeout handoff: core 0 waiting when core 1 expires.
        cycle(1'b0, 2'b00, 2'b00);
        check("tho_reset tf", 8'(timeout_flag), 8'h0);
        cycle(1'b1, 2'b10, 2'b00);
        check("tho_enter grant", 8'(grant), 8'h2);
        for (int c = 2; c <= int'(MH); c++) begin
            cycle(1'b1, 2'b11, 2'b00);
            check($sformatf("tho_hold%0d grant", c), 8'(grant), 8'h2);
            check($sformatf("tho_hold%0d lock", c), 8'(lock), 8'h1);
        end
        cycle(1'b1, 2'b11, 2'b00);
        check_all("tho_handoff", 2'b01, 2'b10, 1'b1, 2'b10, 1'b1);
        check("tho_handoff hold_cnt", 8'(dut.hold_cnt), 8'h0);

        // Release coinciding with expiry is a normal end, not a timeout.
        cycle(1'b0, 2'b00, 2'b00);
        cycle(1'b1, 2'b01, 2'b00);
        for (int c = 2; c <= int'(MH); c++) cycle(1'b1, 2'b01, 2'b00);
        cycle(1'b1, 2'b01, 2'b01);
        check_all("rel_at_expiry", 2'b00, 2'b01, 1'b1, 2'b00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_lock_arbiter.md
MEM_LOCK_ARBITER -- requirements
Module: mem_lock_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 64, meaning the maximum number of consecutive cycles one core may hold the memory lock; legal range 2..255.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004 Port: need_lock  input  2  per-core request level; bit i held high by core i for its whole critical section.
REQ-005 Port: release  input  2  per-core one-cycle pulse ending core i's critical section.
REQ-006 Port: grant  output  2  registered, one-hot or zero; bit i means core i owns the shared memory.
REQ-007 Port: lock  output  2  registered stall; bit i means core i is requesting but not granted.
REQ-008 Port: whose_turn  output  1  registered; the core that wins the next simultaneous request.
REQ-009 Port: timeout_flag  output  2  registered, sticky; bit i means core i's grant was revoked by MAX_HOLD expiry.
REQ-010 Port: busy  output  1  registered; high whenever grant is nonzero.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, OWN0 and OWN1, with grant = 2'b01 in OWN0, 2'b10 in OWN1 and 2'b00 in IDLE.
REQ-012 In IDLE with need_lock = 2'b11, the FSM SHALL go to OWN(whose_turn) and set whose_turn to the other core.
REQ-013 In IDLE with a single requester k, the FSM SHALL go to OWNk and set whose_turn to 1-k.
REQ-014 Grant latency SHALL be one cycle: grant[k] rises on the edge after need_lock[k] is first sampled high in IDLE.
REQ-015 In OWNk, the end-of-ownership condition is release[k]=1, need_lock[k]=0, or hold_cnt = MAX_HOLD-1.
- REQ-015a On that condition, if need_lock[1-k]=1, the FSM SHALL go directly to OWN(1-k) (no idle bubble) and set whose_turn to k.
- REQ-015b On that condition, if need_lock[1-k]=0, the FSM SHALL go to IDLE.
REQ-016 release[j] for a non-owner j SHALL be ignored, as SHALL release in IDLE.
REQ-017 hold_cnt SHALL clear to 0 on every grant entry or handoff, increment by 1 each cycle in OWNk, and never wrap.
REQ-018 Timeout SHALL take priority only when release and need_lock do not already end ownership in the same cycle; only a timeout sets timeout_flag[k].
REQ-019 The next value of lock[i] SHALL be need_lock[i] AND NOT next_grant[i], registered with grant.
REQ-020 busy SHALL equal the OR of the next grant bits, registered.
REQ-021 grant SHALL never be 2'b11; a grant bit SHALL never be asserted to a core whose need_lock was low in the deciding cycle.

Reset
REQ-022 With rst=0 at a clock edge, the block SHALL set state=IDLE, grant=2'b00, lock=2'b00, whose_turn=0, timeout_flag=2'b00, busy=0 and hold_cnt=0, regardless of any other input.
REQ-023 An active reset during OWNk SHALL drop grant on that same edge; the first arbitration happens on the first edge with rst=1.

Structure
REQ-024 The shared package mem_lock_pkg SHALL hold the state enum (IDLE, OWN0, OWN1) and the MAX_HOLD default constant.
REQ-025 Hold-timer logic SHALL be one sub-module, lock_hold_timer, providing a clear input, an enable input and an expired output.

Verification
REQ-026 The bench SHALL cover each of the following scenarios (MAX_HOLD = 8):
- Single request: need_lock=01 for 1 cycle -> next edge grant=01, lock=00, busy=1, whose_turn=1.
- Simultaneous request after reset: need_lock=11 -> grant=01, lock=10; release[0] pulse -> next edge grant=10, lock=00, whose_turn=0.
- Fairness: two rounds of need_lock=11 with releases -> grants alternate 01, 10, 01, 10.
- Timeout: core 1 holds need_lock=10 with no release -> grant=10 for exactly 8 cycles, then grant=00, timeout_flag=10 (sticky), hold_cnt=0.
- Timeout handoff: timeout while need_lock[0]=1 -> grant goes from 10 to 01 on the same edge, timeout_flag=10.
- Non-owner release and reset: release=10 while grant=01 -> no change; rst=0 mid-OWN0 -> all outputs 0 on that edge.
